// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single shared memory port.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on a tie instead of fixed data priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_req,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        port_q;      // granted port: 1 = data, 0 = fetch
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        i_ack_q;
  logic        d_ack_q;
  logic        err_q;
  logic        grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_q;      // last granted port: 1 = data, 0 = fetch

  always_comb begin
    grant_d = d_req;
    if (i_req && d_req) grant_d = ~last_q;
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q    <= 1'b0;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            state_q <= BUSY;
            port_q  <= grant_d;
            addr_q  <= grant_d ? d_addr : i_addr;
            write_q <= grant_d & d_write;
            wdata_q <= grant_d ? d_wdata : '0;
            cnt_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= grant_d;
`endif
          end
        end
        BUSY: begin
          // An ack on the limit cycle wins over the timeout.
          if (m_ack) begin
            state_q <= DONE;
            i_ack_q <= ~port_q;
            d_ack_q <= port_q;
            if (!port_q)      i_rdata_q <= m_rdata;
            else if (!write_q) d_rdata_q <= m_rdata;
          end else if (cnt_q == LIMIT) begin
            state_q <= DONE;
            i_ack_q <= ~port_q;
            d_ack_q <= port_q;
            err_q   <= 1'b1;
            if (!port_q)      i_rdata_q <= '0;
            else if (!write_q) d_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory-side outputs are only live while a transaction is in flight.
  assign m_req       = (state_q == BUSY);
  assign m_write     = m_req & write_q;
  assign m_addr      = m_req ? addr_q  : '0;
  assign m_wdata     = m_req ? wdata_q : '0;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
